// File: rtl/gpio_bank_if.sv
// Data-memory bus slave port for gpio_bank: decoded select, strobes,
// byte offset, write data and the registered read return.
interface gpio_bank_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  sel_i;
    logic                  we_i;
    logic                  re_i;
    logic [4:0]            addr_i;
    logic [DATA_WIDTH-1:0] wdata_i;
    logic [DATA_WIDTH-1:0] rdata_o;
    logic                  rvalid_o;

    modport master (
        output sel_i, we_i, re_i, addr_i, wdata_i,
        input  rdata_o, rvalid_o
    );

    modport slave (
        input  sel_i, we_i, re_i, addr_i, wdata_i,
        output rdata_o, rvalid_o
    );
endinterface

// File: rtl/gpio_bank.sv
// Memory-mapped GPIO bank: OUT/DIR/TOGGLE registers, double-flop input sync,
// registered one-cycle reads. Edge interrupts are built only with GPIO_IRQ_EN.
module gpio_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int GPIO_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    gpio_bank_if.slave            bus,
    input  logic [GPIO_WIDTH-1:0] gpio_in,
    output logic [GPIO_WIDTH-1:0] gpio_out,
    output logic [GPIO_WIDTH-1:0] gpio_oe,
    output logic                  irq
);

    localparam logic [2:0] A_OUT      = 3'd0;
    localparam logic [2:0] A_IN       = 3'd1;
    localparam logic [2:0] A_DIR      = 3'd2;
    localparam logic [2:0] A_TOGGLE   = 3'd3;
    localparam logic [2:0] A_IRQ_EN   = 3'd4;
    localparam logic [2:0] A_EDGE_SEL = 3'd5;
    localparam logic [2:0] A_STATUS   = 3'd6;

    logic                  wr_en;
    logic                  rd_en;
    logic [2:0]            idx;
    logic [GPIO_WIDTH-1:0] wdata_g;
    logic [GPIO_WIDTH-1:0] out_q;
    logic [GPIO_WIDTH-1:0] dir_q;
    logic [GPIO_WIDTH-1:0] sync1_q;
    logic [GPIO_WIDTH-1:0] sync2_q;
    logic [GPIO_WIDTH-1:0] rd_val_g;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  unused_bus;

    assign wr_en   = bus.sel_i & bus.we_i;
    assign rd_en   = bus.sel_i & bus.re_i;
    assign idx     = bus.addr_i[4:2];
    assign wdata_g = bus.wdata_i[GPIO_WIDTH-1:0];

    // Byte-lane bits and data bits above GPIO_WIDTH carry no state.
    assign unused_bus = ^{bus.addr_i[1:0], bus.wdata_i};

    assign gpio_out = out_q;
    assign gpio_oe  = dir_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q   <= '0;
            dir_q   <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= gpio_in;
            sync2_q <= sync1_q;
            if (wr_en && idx == A_OUT) begin
                out_q <= wdata_g;
            end else if (wr_en && idx == A_TOGGLE) begin
                out_q <= out_q ^ wdata_g;
            end
            if (wr_en && idx == A_DIR) begin
                dir_q <= wdata_g;
            end
        end
    end

`ifdef GPIO_IRQ_EN
    logic [GPIO_WIDTH-1:0] prev_q;
    logic [GPIO_WIDTH-1:0] irq_en_q;
    logic [GPIO_WIDTH-1:0] edge_sel_q;
    logic [GPIO_WIDTH-1:0] irq_status_q;
    logic [GPIO_WIDTH-1:0] edge_det;
    logic [GPIO_WIDTH-1:0] w1c_mask;

    assign edge_det = (sync2_q & ~prev_q & ~edge_sel_q)
                    | (~sync2_q & prev_q & edge_sel_q);
    assign w1c_mask = (wr_en && idx == A_STATUS) ? wdata_g : '0;
    assign irq      = |(irq_status_q & irq_en_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q       <= '0;
            irq_en_q     <= '0;
            edge_sel_q   <= '0;
            irq_status_q <= '0;
        end else begin
            prev_q <= sync2_q;
            if (wr_en && idx == A_IRQ_EN) begin
                irq_en_q <= wdata_g;
            end
            if (wr_en && idx == A_EDGE_SEL) begin
                edge_sel_q <= wdata_g;
            end
            // A fresh edge outranks a simultaneous write-1-to-clear.
            irq_status_q <= (irq_status_q & ~w1c_mask) | edge_det;
        end
    end
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rd_val_g = '0;
        case (idx)
            A_OUT:      rd_val_g = out_q;
            A_IN:       rd_val_g = sync2_q;
            A_DIR:      rd_val_g = dir_q;
`ifdef GPIO_IRQ_EN
            A_IRQ_EN:   rd_val_g = irq_en_q;
            A_EDGE_SEL: rd_val_g = edge_sel_q;
            A_STATUS:   rd_val_g = irq_status_q;
`endif
            default:    rd_val_g = '0;
        endcase
        rd_word = '0;
        rd_word[GPIO_WIDTH-1:0] = rd_val_g;
    end

    // Read data is captured from pre-edge state, so a same-cycle write is not visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.rdata_o  <= '0;
            bus.rvalid_o <= 1'b0;
        end else begin
            bus.rvalid_o <= rd_en;
            bus.rdata_o  <= rd_en ? rd_word : '0;
        end
    end

endmodule

// File: doc/gpio_bank.md
# gpio_bank

Parametrised memory-mapped GPIO peripheral replacing the fixed 8-bit GPIO ports of the pipelined RISC-V data path.
- Provides per-pin direction control, double-flop input synchronisation, atomic toggle, and per-pin edge-detect interrupts.
- Attaches to the data-memory bus as an address-decoded slave with a registered one-cycle read.

## Interface
- DATA_WIDTH, 32, bus data width.
- GPIO_WIDTH, 8, number of pins; 1..DATA_WIDTH.
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- sel_i  in  1  bus select from address decoder.
- we_i  in  1  write strobe, qualified by sel_i.
- re_i  in  1  read strobe, qualified by sel_i.
- addr_i  in  5  byte offset; addr_i[1:0] ignored.
- wdata_i  in  DATA_WIDTH  write data.
- rdata_o  out  DATA_WIDTH  registered read data.
- rvalid_o  out  1  high one cycle when rdata_o is valid.
- gpio_in  in  GPIO_WIDTH  asynchronous pin inputs.
- gpio_out  out  GPIO_WIDTH  output register.
- gpio_oe  out  GPIO_WIDTH  output enables; 1 = drive.
- irq  out  1  level interrupt request.

## Operation
- Register map (word offsets):
  - 0x00 OUT, RW.
  - 0x04 IN, RO; synchronised pins.
  - 0x08 DIR, RW.
  - 0x0C TOGGLE, WO; OUT ^= wdata; reads 0.
  - 0x10 IRQ_EN, RW.
  - 0x14 EDGE_SEL, RW; 0 = rising, 1 = falling.
  - 0x18 IRQ_STATUS, RW1C.
  - 0x1C reserved; reads 0, writes ignored.
- Bit handling:
  - Bits [DATA_WIDTH-1:GPIO_WIDTH] of every register read 0; writes to them are ignored.
  - When GPIO_WIDTH == DATA_WIDTH, there are no upper bits.
- Synchroniser: sync1 <= gpio_in, sync2 <= sync1, prev <= sync2. IN = sync2.
- Edge detection per bit i:
  - Rising: sync2[i] & ~prev[i].
  - Falling: ~sync2[i] & prev[i].
  - EDGE_SEL[i] selects which one counts.
- Status: a detected edge sets IRQ_STATUS[i] regardless of IRQ_EN[i].
- Interrupt: irq = |(IRQ_STATUS & IRQ_EN).
- Write-1-to-clear versus new edge in the same cycle: set wins and the bit stays 1.
- Accesses:
  - we_i and re_i with sel_i low are ignored.
  - we_i and re_i both high in the same cycle: the write commits and rdata_o returns the pre-write value.
- gpio_out = OUT and gpio_oe = DIR, each driven directly from its register. Pins with DIR = 0 still update OUT.
- Reset (asynchronous, immediate): all registers, sync1, sync2, prev, rdata_o and rvalid_o go to 0, so gpio_out = 0, gpio_oe = 0 and irq = 0. An access in flight at reset is dropped.

## Timing
- Write: takes effect at the clock edge where sel_i & we_i is sampled; the new value is visible on gpio_out/gpio_oe after that edge.
- Read: sel_i & re_i sampled at edge k. rdata_o and rvalid_o are valid after edge k for exactly one cycle. rdata_o returns to 0 when rvalid_o is low.
- Back-to-back reads every cycle are supported with no bubbles.
- Input path: gpio_in is stable before edge k.
  - IN reflects it after edge k+1.
  - IRQ_STATUS bit sets at edge k+2.
  - irq is asserted combinationally after edge k+2.
- Pulses narrower than one clk period may be missed. No counting is done; multiple edges before a clear collapse into one status bit.

## Configuration
- GPIO_IRQ_EN defined: IRQ_EN, EDGE_SEL, IRQ_STATUS, the prev register and edge logic are implemented as described.
- GPIO_IRQ_EN undefined:
  - Offsets 0x10, 0x14 and 0x18 read 0 and ignore writes.
  - No prev register or edge logic is instantiated.
  - irq is tied to 0.
  - All other behaviour is unchanged.

## Test plan
- Reset with gpio_in = 0xFF: check gpio_out = 0, gpio_oe = 0, irq = 0. Read 0x04 two cycles after reset deasserts and expect 0xFF; read 0x00 and expect 0 with rvalid_o for one cycle.
- Write OUT = 0xA5, DIR = 0x0F, then TOGGLE = 0xFF -> gpio_out = 0x5A and gpio_oe = 0x0F. Write OUT = 0xFFFFFFFF -> read of OUT returns 0x000000FF.
- IRQ_EN = 0x01, EDGE_SEL = 0, gpio_in[0] rises before edge k -> IRQ_STATUS = 0x01 and irq = 1 after edge k+2. Write 0x01 to 0x18 -> irq = 0 next cycle.
- EDGE_SEL = 0x02, IRQ_EN = 0 -> a falling edge on pin 1 sets IRQ_STATUS = 0x02 while irq stays 0. A subsequent IRQ_EN = 0x02 write asserts irq immediately.
- W1C of bit 0 in the same cycle a new rising edge on pin 0 is detected -> IRQ_STATUS[0] remains 1. Simultaneous re/we to OUT (old 0x11, new 0x22) -> rdata_o = 0x11, then OUT reads 0x22.
- Assert reset mid-read with rvalid_o pending -> rvalid_o = 0 immediately and all registers 0. With GPIO_IRQ_EN undefined, toggling pins leaves irq = 0 and offset 0x18 reads 0.
